button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Produces the clean, one-cycle active-high command pulses (start, move, select) that the game controller consumes.
- Sits between the raw active-low board push-buttons and the controller; replaces the bare inversion of raw keys at the top level.
- Per button: 2-FF synchroniser, debounce, press/release edge detection.
- Optional auto-repeat for held buttons, e.g. scrolling the cursor with move.

Parameters:
- N_BTN, 3, number of independent buttons (bit 0 = start, 1 = move, 2 = select by top-level convention).
- DB_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range >= 2.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- hrd_rst  input  1  asynchronous, active-low reset.
- key_n  input  N_BTN  raw push-buttons, active-low, asynchronous to clk.
- pressed  output  N_BTN  debounced level, active-high (1 = held).
- press  output  N_BTN  one-cycle pulse on accepted press (and on auto-repeat when enabled).
- release  output  N_BTN  one-cycle pulse on accepted release.

Behaviour:
- Reset (hrd_rst = 0, async): all sync flops, pressed, press, release, debounce counters and repeat counters = 0.
- Each bit is fully independent; no priority between buttons; simultaneous events on different bits produce simultaneous pulses.
- Sync: s1 <= ~key_n; s2 <= s1. Only s2 is used downstream.
- Debounce per bit, with counter cnt of width $clog2(DB_CYCLES):
  - If s2 == pressed: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: pressed <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Any glitch where s2 returns to pressed before acceptance restarts the count from 0.
- Latency: with a bounce-free press, pressed rises on the (DB_CYCLES+2)th rising edge, counting the first edge that samples key_n low. Release is symmetric.
- Pulses:
  - press and release are registered and update on the same edge as pressed.
  - press = 1 for exactly one cycle, the first cycle pressed reads 1; release likewise on the first cycle pressed reads 0.
  - press and release are never both high on the same bit.
- Button held through reset: after hrd_rst deasserts, s2 = 1 vs pressed = 0, so a normal press pulse follows after the standard latency.
- Reset mid-debounce: count is discarded; no pulse emitted.
- Counters saturate only through the compare; they never wrap.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - Per bit, a repeat counter rc runs while pressed = 1 and clears on the first cycle pressed = 0.
  - First extra press pulse fires REPEAT_DELAY cycles after the initial press pulse.
  - Further pulses fire every REPEAT_PERIOD cycles while the button stays held.
  - release behaviour is unchanged.
  - Width of rc = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Undefined: no repeat logic is synthesised; exactly one press pulse per accepted press. REPEAT_* parameters are ignored.

Test Plan (bench uses DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: key_n[1] 1->0, held 20 cycles -> pressed[1] rises on edge 6 after the first low sample; press[1] high exactly 1 cycle on that edge; other bits stay 0.
- Bounce: key_n[0] low 2 cycles, high 1, low 10 -> no pulse during the bounce; single press[0] pulse 6 edges after the final low sample.
- Release plus simultaneous events: bits 0 and 2 pressed on the same cycle, later released on the same cycle -> press[0] and press[2] asserted on the same edge; release[0] and release[2] likewise. press and release never overlap.
- Reset behaviour: assert hrd_rst mid-count (cnt = 2), and separately hold key_n[2] low across reset -> all outputs 0 immediately and no pulse from the aborted count; after deassert, press[2] fires 6 edges later.
- Short glitch: key_n[1] low for 3 cycles only -> pressed, press and release remain 0 throughout.
- With BUTTON_AUTO_REPEAT_EN, hold key_n[1] low 30 cycles -> press[1] at t0, t0+10, t0+13, t0+16, ...; release[1] once after key_n returns high. Without the macro -> single press[1] pulse only.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw board keys and the game controller.
// The debouncer sits on the slave side; the key source and pulse consumer on the master side.
// release_p carries the one-cycle release pulse ("release" is a reserved word).
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] key_n;      // raw push-buttons, active-low, asynchronous
    logic [N_BTN-1:0] pressed;    // debounced level, 1 = held
    logic [N_BTN-1:0] press;      // one-cycle pulse on accepted press / auto-repeat
    logic [N_BTN-1:0] release_p;  // one-cycle pulse on accepted release

    modport master (
        output key_n,
        input  pressed,
        input  press,
        input  release_p
    );

    modport slave (
        input  key_n,
        output pressed,
        output press,
        output release_p
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button conditioner: 2-FF synchroniser, debounce, press/release pulse generation.
// Each bit is independent. Optional auto-repeat of press pulses while a button is
// held is enabled by defining BUTTON_AUTO_REPEAT_EN; without it no repeat logic exists.
module button_conditioner #(
    parameter int unsigned N_BTN         = 3,
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                hrd_rst,
    button_conditioner_if.slave btn
);

    localparam int unsigned   CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (DB_CYCLES < 2) begin : g_db_check
        $error("button_conditioner: DB_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_rpt_check
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    logic [N_BTN-1:0] pressed_q, pressed_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] accept;
    logic [N_BTN-1:0] rep_fire;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];

    // Synchroniser next state: invert to active-high on entry, only s2 is used downstream.
    always_comb begin
        s1_d = ~btn.key_n;
        s2_d = s1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk or negedge hrd_rst) begin
        if (!hrd_rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Debounce: count consecutive cycles where s2 disagrees with the accepted level.
    always_comb begin
        pressed_d = pressed_q;
        accept    = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == pressed_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                accept[i]    = 1'b1;
                pressed_d[i] = s2_q[i];
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounce counters and accepted level.
    always_ff @(posedge clk or negedge hrd_rst) begin
        if (!hrd_rst) begin
            pressed_q <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pressed_q <= pressed_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned   RW          = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]    rc_q [N_BTN];
    logic [RW-1:0]    rc_d [N_BTN];
    logic [N_BTN-1:0] rpt_q, rpt_d;  // first repeat already issued -> use REPEAT_PERIOD

    // Repeat timing: count held cycles, restart after each repeat; cleared while
    // released and on the releasing edge so a repeat never collides with release.
    always_comb begin
        rep_fire = '0;
        rpt_d    = rpt_q;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            rc_d[i] = rc_q[i];
            if (!pressed_q[i] || accept[i]) begin
                rc_d[i]  = '0;
                rpt_d[i] = 1'b0;
            end else if (rc_q[i] == (rpt_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire[i] = 1'b1;
                rc_d[i]     = '0;
                rpt_d[i]    = 1'b1;
            end else begin
                rc_d[i] = rc_q[i] + RW'(1);
            end
        end
    end

    // Repeat counters.
    always_ff @(posedge clk or negedge hrd_rst) begin
        if (!hrd_rst) begin
            rpt_q <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                rc_q[i] <= '0;
            end
        end else begin
            rpt_q <= rpt_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                rc_q[i] <= rc_d[i];
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Pulses: registered so they appear on the same edge as the pressed change.
    always_comb begin
        press_d   = (accept & s2_q) | rep_fire;
        release_d = accept & ~s2_q;
    end

    // Pulse registers.
    always_ff @(posedge clk or negedge hrd_rst) begin
        if (!hrd_rst) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn.pressed   = pressed_q;
    assign btn.press     = press_q;
    assign btn.release_p = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner. A window-based reference model predicts
// pulse events per edge into a queue; a negedge monitor pops and checks them.
// Define BUTTON_AUTO_REPEAT_EN for both RTL and bench to exercise auto-repeat.
module tb_button_conditioner;
    localparam int N  = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk     = 1'b0;
    logic hrd_rst = 1'b0;

    button_conditioner_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .N_BTN(N),
        .DB_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .hrd_rst(hrd_rst),
        .btn(bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
    } ev_t;

    ev_t          exp_q[$];
    logic [N-1:0] samples[$];  // active-high key samples, newest at index 0
    logic [N-1:0] m_pressed = '0;
    int           held[N];
    int           cyc   = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    function automatic logic [N-1:0] seen(input int j);
        if (j < samples.size()) return samples[j];
        return '0;
    endfunction

    // Reference model: a level is accepted once the debouncer has seen DB consecutive
    // samples (which are two edges old because of the synchroniser) all disagreeing.
    logic [N-1:0] m_acc, m_pr, m_rl, m_w;
    ev_t          m_ev;
    always @(posedge clk) begin
        cyc++;
        if (!hrd_rst) begin
            samples.delete();
            m_pressed = '0;
            for (int b = 0; b < N; b++) held[b] = 0;
        end else begin
            samples.push_front(~bif.key_n);
            if (samples.size() > DB + 2) void'(samples.pop_back());
            m_acc = '1;
            for (int j = 2; j <= DB + 1; j++) begin
                m_w   = seen(j);
                m_acc = m_acc & (m_w ^ m_pressed);
            end
            m_pr      = m_acc & ~m_pressed;
            m_rl      = m_acc & m_pressed;
            m_pressed = m_pressed ^ m_acc;
            for (int b = 0; b < N; b++) begin
                if (m_pr[b] || !m_pressed[b]) begin
                    held[b] = 0;
                end else begin
                    held[b]++;
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (held[b] == RD || (held[b] > RD && (held[b] - RD) % RP == 0)) m_pr[b] = 1'b1;
`endif
                end
            end
            if ((m_pr | m_rl) != '0) begin
                m_ev.cyc = cyc;
                m_ev.pr  = m_pr;
                m_ev.rl  = m_rl;
                exp_q.push_back(m_ev);
            end
        end
    end

    // Monitor: checks level every cycle and pops an expected event whenever a pulse shows.
    ev_t mon_ev;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse cyc=%0d: got no pulse, required press=%b release=%b",
                     exp_q[0].cyc, exp_q[0].pr, exp_q[0].rl);
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (bif.pressed !== m_pressed) begin
            n_bad++;
            $display("FAIL pressed_level cyc=%0d: got %b, required %b", cyc, bif.pressed, m_pressed);
        end
        n_cmp++;
        if ((bif.press & bif.release_p) !== '0) begin
            n_bad++;
            $display("FAIL press_release_overlap cyc=%0d: got %b, required 000",
                     cyc, bif.press & bif.release_p);
        end
        if ((bif.press | bif.release_p) !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                n_bad++;
                $display("FAIL unexpected_pulse cyc=%0d: got press=%b release=%b, required none",
                         cyc, bif.press, bif.release_p);
            end else begin
                mon_ev = exp_q.pop_front();
                if (bif.press !== mon_ev.pr || bif.release_p !== mon_ev.rl) begin
                    n_bad++;
                    $display("FAIL pulse_value cyc=%0d: got press=%b release=%b, required press=%b release=%b",
                             cyc, bif.press, bif.release_p, mon_ev.pr, mon_ev.rl);
                end
            end
        end
    end

    // Inputs change 1 time unit after the falling edge, well away from sampling.
    task automatic hold(input logic [N-1:0] kn, input int n);
        bif.key_n = kn;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_cleared(input string what);
        n_cmp++;
        if ({bif.pressed, bif.press, bif.release_p} !== '0) begin
            n_bad++;
            $display("FAIL %s: got pressed=%b press=%b release=%b, required all 0",
                     what, bif.pressed, bif.press, bif.release_p);
        end
    endtask

    task automatic do_reset(input int n);
        hrd_rst = 1'b0;
        #1;
        check_cleared("reset_clear");
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        hrd_rst = 1'b1;
    endtask

    logic [N-1:0] rv;
    initial begin
        bif.key_n = '1;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check_cleared("reset_state");
        hrd_rst = 1'b1;
        hold('1, 8);

        // clean press on move, then release
        hold(3'b101, 20);
        hold(3'b111, 15);
        // bouncing press on start
        hold(3'b110, 2);
        hold(3'b111, 1);
        hold(3'b110, 10);
        hold(3'b111, 12);
        // simultaneous press and release on start and select
        hold(3'b010, 12);
        hold(3'b111, 12);
        // reset mid-count on start (counter at 2)
        hold(3'b110, 4);
        bif.key_n = '1;
        do_reset(3);
        hold(3'b111, 12);
        // select held through reset
        hold(3'b011, 10);
        do_reset(3);
        hold(3'b011, 12);
        hold(3'b111, 12);
        // short glitch on move
        hold(3'b101, 3);
        hold(3'b111, 12);
        // long hold on move (auto-repeat when enabled)
        hold(3'b101, 30);
        hold(3'b111, 12);

        // random segments
        for (int s = 0; s < 80; s++) begin
            rv = N'($urandom_range(0, (1 << N) - 1));
            hold(rv, int'($urandom_range(1, 9)));
        end
        hold(3'b010, 24);
        hold('1, 20);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
